mem_bus_arbiter: RTL and testbench

//  Shares one line-burst memory port between the I-cache (requester 0, read-only refill)
//  and the D-cache (requester 1, refill or writeback). Selects a requester round-robin,

---
 rtl/mem_bus_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one line-burst memory port between the I-cache (0) and D-cache (1).
// Optional per-requester wait-cycle counters are built when ARB_PERF_CNT_EN is defined.
module mem_bus_arbiter #(
    parameter int BEATS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [1:0]  req_we,
    input  logic [63:0] req_addr,
    output logic [1:0]  gnt,
    input  logic [63:0] wdata,
    input  logic [7:0]  wstrb,
    output logic        dc_wready,
    output logic [1:0]  rvalid,
    output logic [63:0] rdata,
    output logic        rlast,
    output logic [1:0]  bvalid,
    output logic        mem_avalid,
    input  logic        mem_aready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic        mem_wvalid,
    input  logic        mem_wready,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wstrb,
    output logic        mem_wlast,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    input  logic        mem_bvalid
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [63:0] ic_wait_cnt,
    output logic [63:0] dc_wait_cnt
`endif
);

    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, RDATA, RESP} state_t;

    state_t        state_reg, state_next;
    logic          owner_reg, owner_next;
    logic          we_reg, we_next;
    logic          last_owner_reg, last_owner_next;
    logic [31:0]   addr_reg, addr_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          owner_sel;
    logic [1:0]    owner_oh;
    logic          cnt_last;

    // The I-cache can never write back, so its we bit carries no information.
    logic unused_ic_we;
    assign unused_ic_we = req_we[0];

    assign owner_oh = owner_reg ? 2'b10 : 2'b01;
    assign cnt_last = (cnt_reg == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            owner_reg      <= 1'b0;
            we_reg         <= 1'b0;
            last_owner_reg <= 1'b1;
            addr_reg       <= '0;
            cnt_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            we_reg         <= we_next;
            last_owner_reg <= last_owner_next;
            addr_reg       <= addr_next;
            cnt_reg        <= cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        we_next         = we_reg;
        last_owner_next = last_owner_reg;
        addr_next       = addr_reg;
        cnt_next        = cnt_reg;
        owner_sel       = 1'b0;
        gnt             = 2'b00;
        dc_wready       = 1'b0;
        rvalid          = 2'b00;
        rdata           = '0;
        rlast           = 1'b0;
        bvalid          = 2'b00;
        mem_avalid      = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_wvalid      = 1'b0;
        mem_wdata       = '0;
        mem_wstrb       = '0;
        mem_wlast       = 1'b0;

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (|req) begin
                    // On a tie the requester not served last time wins.
                    owner_sel  = (req == 2'b11) ? ~last_owner_reg : req[1];
                    owner_next = owner_sel;
                    we_next    = req_we[1] & owner_sel;
                    addr_next  = owner_sel ? req_addr[63:32] : req_addr[31:0];
                    state_next = ADDR;
                end
            end
            ADDR: begin
                mem_avalid = 1'b1;
                mem_addr   = addr_reg;
                mem_we     = we_reg;
                if (mem_aready) begin
                    gnt             = owner_oh;
                    last_owner_next = owner_reg;
                    cnt_next        = '0;
                    state_next      = we_reg ? WDATA : RDATA;
                end
            end
            WDATA: begin
                mem_wvalid = 1'b1;
                mem_wdata  = wdata;
                mem_wstrb  = wstrb;
                mem_wlast  = cnt_last;
                dc_wready  = mem_wready;
                if (mem_wready) begin
                    cnt_next = cnt_reg + CW'(1);
                    if (cnt_last) begin
                        state_next = RESP;
                    end
                end
            end
            RDATA: begin
                rdata = mem_rdata;
                if (mem_rvalid) begin
                    rvalid   = owner_oh;
                    rlast    = cnt_last;
                    cnt_next = cnt_reg + CW'(1);
                    if (cnt_last) begin
                        state_next = IDLE;
                    end
                end
            end
            RESP: begin
                if (mem_bvalid) begin
                    bvalid     = owner_oh;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef ARB_PERF_CNT_EN
    logic [63:0] wait_cnt_reg [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_wait_cnt
        always_ff @(posedge clk) begin
            if (rst) begin
                wait_cnt_reg[gi] <= '0;
            end else if (req[gi] && !gnt[gi]) begin
                wait_cnt_reg[gi] <= wait_cnt_reg[gi] + 64'd1;
            end
        end
    end

    assign ic_wait_cnt = wait_cnt_reg[0];
    assign dc_wait_cnt = wait_cnt_reg[1];
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (BEATS=4): reads, writeback, arbitration, stalls, bubbles, reset abort.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  req_we;
    logic [63:0] req_addr;
    logic [1:0]  gnt;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        dc_wready;
    logic [1:0]  rvalid;
    logic [63:0] rdata;
    logic        rlast;
    logic [1:0]  bvalid;
    logic        mem_avalid;
    logic        mem_aready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_wlast;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        mem_bvalid;
`ifdef ARB_PERF_CNT_EN
    logic [63:0] ic_wait_cnt;
    logic [63:0] dc_wait_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.BEATS(4)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
        .gnt(gnt), .wdata(wdata), .wstrb(wstrb), .dc_wready(dc_wready),
        .rvalid(rvalid), .rdata(rdata), .rlast(rlast), .bvalid(bvalid),
        .mem_avalid(mem_avalid), .mem_aready(mem_aready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_wlast(mem_wlast),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_bvalid(mem_bvalid)
`ifdef ARB_PERF_CNT_EN
        , .ic_wait_cnt(ic_wait_cnt), .dc_wait_cnt(dc_wait_cnt)
`endif
    );

    logic any_out;
    assign any_out = |{gnt, dc_wready, rvalid, rdata, rlast, bvalid, mem_avalid, mem_we,
                       mem_addr, mem_wvalid, mem_wdata, mem_wstrb, mem_wlast};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 2'b00; req_we = 2'b00; req_addr = '0;
        wdata = '0; wstrb = '0; mem_aready = 1'b0; mem_wready = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = '0; mem_bvalid = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (any_out !== 1'b0) begin
            n_err++; $display("FAIL reset_outputs: got nonzero outputs, expected all 0");
        end
`ifdef ARB_PERF_CNT_EN
        n_cmp++;
        if ({ic_wait_cnt, dc_wait_cnt} !== 128'd0) begin
            n_err++; $display("FAIL reset_perf: got %0d/%0d expected 0/0", ic_wait_cnt, dc_wait_cnt);
        end
`endif
        rst = 1'b0;
        tick();
        $display("reset done");
    endtask

    task automatic test_ic_read;
        req = 2'b01; req_we = 2'b00; req_addr = {32'h0, 32'h8000_0000}; mem_aready = 1'b1;
        #1;
        n_cmp++;
        if ({mem_avalid, gnt} !== 3'b000) begin
            n_err++; $display("FAIL ic_idle: got avalid/gnt %b expected 000", {mem_avalid, gnt});
        end
        tick();
        n_cmp++;
        if ({mem_avalid, mem_we, mem_addr, gnt} !== {1'b1, 1'b0, 32'h8000_0000, 2'b01}) begin
            n_err++; $display("FAIL ic_addr: got avalid=%b we=%b addr=%h gnt=%b expected 1 0 80000000 01",
                              mem_avalid, mem_we, mem_addr, gnt);
        end
        req = 2'b00;
        tick();
        for (int b = 0; b < 4; b++) begin
            mem_rvalid = 1'b1; mem_rdata = 64'hA0 + 64'(b);
            #1;
            n_cmp++;
            if ({rvalid, rdata, rlast} !== {2'b01, 64'hA0 + 64'(b), (b == 3)}) begin
                n_err++; $display("FAIL ic_beat%0d: got rvalid=%b rdata=%h rlast=%b expected 01 %h %b",
                                  b, rvalid, rdata, rlast, 64'hA0 + 64'(b), (b == 3));
            end
            tick();
        end
        mem_rvalid = 1'b0;
        #1;
        n_cmp++;
        if (any_out !== 1'b0) begin
            n_err++; $display("FAIL ic_end_idle: got nonzero outputs, expected idle");
        end
        $display("lone I-cache read checked");
    endtask

    task automatic test_dc_write;
        logic [63:0] exp_w;
        req = 2'b10; req_we = 2'b10; req_addr = {32'h8000_1000, 32'h0}; mem_aready = 1'b1;
        tick();
        n_cmp++;
        if ({mem_avalid, mem_we, mem_addr, gnt} !== {1'b1, 1'b1, 32'h8000_1000, 2'b10}) begin
            n_err++; $display("FAIL dc_addr: got avalid=%b we=%b addr=%h gnt=%b expected 1 1 80001000 10",
                              mem_avalid, mem_we, mem_addr, gnt);
        end
        req = 2'b00; req_we = 2'b00;
        tick();
        for (int b = 0; b < 4; b++) begin
            if (b == 2) begin
                mem_wready = 1'b0;
                #1;
                n_cmp++;
                if ({mem_wvalid, dc_wready, mem_wlast} !== 3'b100) begin
                    n_err++; $display("FAIL dc_wbubble: got wvalid/wready/wlast %b expected 100",
                                      {mem_wvalid, dc_wready, mem_wlast});
                end
                tick();
            end
            exp_w = 64'h11 * 64'(b + 1);
            mem_wready = 1'b1; wdata = exp_w; wstrb = 8'hFF;
            #1;
            n_cmp++;
            if ({mem_wvalid, dc_wready, mem_wdata, mem_wstrb, mem_wlast} !==
                {1'b1, 1'b1, exp_w, 8'hFF, (b == 3)}) begin
                n_err++; $display("FAIL dc_wbeat%0d: got wvalid=%b wready=%b wdata=%h wstrb=%h wlast=%b expected 1 1 %h ff %b",
                                  b, mem_wvalid, dc_wready, mem_wdata, mem_wstrb, mem_wlast, exp_w, (b == 3));
            end
            tick();
        end
        mem_wready = 1'b0; mem_bvalid = 1'b0;
        #1;
        n_cmp++;
        if ({bvalid, mem_wvalid} !== 3'b000) begin
            n_err++; $display("FAIL dc_resp_wait: got bvalid=%b wvalid=%b expected 00 0", bvalid, mem_wvalid);
        end
        tick();
        mem_bvalid = 1'b1;
        #1;
        n_cmp++;
        if (bvalid !== 2'b10) begin
            n_err++; $display("FAIL dc_bvalid: got %b expected 10", bvalid);
        end
        tick();
        mem_bvalid = 1'b0;
        #1;
        n_cmp++;
        if (any_out !== 1'b0) begin
            n_err++; $display("FAIL dc_end_idle: got nonzero outputs, expected idle");
        end
        $display("lone D-cache writeback checked");
    endtask

    task automatic test_round_robin;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 2'b11; req_we = 2'b00; req_addr = {32'h9000_0000, 32'h8800_0000}; mem_aready = 1'b1;
        tick();
        n_cmp++;
        if ({gnt, mem_addr} !== {2'b01, 32'h8800_0000}) begin
            n_err++; $display("FAIL rr_first: got gnt=%b addr=%h expected 01 88000000", gnt, mem_addr);
        end
        req = 2'b10;
        tick();
        mem_rvalid = 1'b1;
        #1;
        n_cmp++;
        if (rvalid !== 2'b01) begin
            n_err++; $display("FAIL rr_first_rvalid: got %b expected 01", rvalid);
        end
        repeat (4) tick();
        mem_rvalid = 1'b0;
        tick();
        n_cmp++;
        if ({gnt, mem_addr} !== {2'b10, 32'h9000_0000}) begin
            n_err++; $display("FAIL rr_second: got gnt=%b addr=%h expected 10 90000000", gnt, mem_addr);
        end
        req = 2'b11;
        tick();
        mem_rvalid = 1'b1;
        #1;
        n_cmp++;
        if (rvalid !== 2'b10) begin
            n_err++; $display("FAIL rr_second_rvalid: got %b expected 10", rvalid);
        end
        repeat (4) tick();
        mem_rvalid = 1'b0;
        tick();
        n_cmp++;
        if ({gnt, mem_addr} !== {2'b01, 32'h8800_0000}) begin
            n_err++; $display("FAIL rr_third: got gnt=%b addr=%h expected 01 88000000", gnt, mem_addr);
        end
        req = 2'b00;
        tick();
        mem_rvalid = 1'b1;
        repeat (4) tick();
        mem_rvalid = 1'b0;
        $display("round-robin checked");
    endtask

    task automatic test_aready_stall;
        req = 2'b01; req_addr = {32'h0, 32'h8000_2000}; mem_aready = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            #1;
            n_cmp++;
            if ({mem_avalid, mem_addr, gnt} !== {1'b1, 32'h8000_2000, 2'b00}) begin
                n_err++; $display("FAIL stall%0d: got avalid=%b addr=%h gnt=%b expected 1 80002000 00",
                                  i, mem_avalid, mem_addr, gnt);
            end
            tick();
        end
        mem_aready = 1'b1;
        #1;
        n_cmp++;
        if ({mem_avalid, gnt} !== 3'b101) begin
            n_err++; $display("FAIL stall_gnt: got avalid/gnt %b expected 101", {mem_avalid, gnt});
        end
        req = 2'b00;
        tick();
        mem_rvalid = 1'b1;
        repeat (4) tick();
        mem_rvalid = 1'b0;
        $display("address stall checked");
    endtask

    task automatic test_rvalid_bubbles;
        int pat [6] = '{1, 0, 1, 0, 1, 1};
        int seen = 0;
        req = 2'b01; req_addr = {32'h0, 32'h8000_4000}; mem_aready = 1'b1;
        tick();
        req = 2'b00;
        tick();
        for (int i = 0; i < 6; i++) begin
            mem_rvalid = (pat[i] != 0); mem_rdata = 64'hB0 + 64'(i);
            #1;
            n_cmp++;
            if ({rvalid, rlast} !== {((pat[i] != 0) ? 2'b01 : 2'b00), ((pat[i] != 0) && (seen == 3))}) begin
                n_err++; $display("FAIL bubble%0d: got rvalid=%b rlast=%b expected %b %b", i, rvalid, rlast,
                                  ((pat[i] != 0) ? 2'b01 : 2'b00), ((pat[i] != 0) && (seen == 3)));
            end
            if (pat[i] != 0) seen++;
            tick();
        end
        mem_rvalid = 1'b0;
        #1;
        n_cmp++;
        if (any_out !== 1'b0) begin
            n_err++; $display("FAIL bubble_end_idle: got nonzero outputs, expected idle");
        end
        $display("read bubbles checked");
    endtask

    task automatic test_rst_mid;
        req = 2'b01; req_addr = {32'h0, 32'h8000_5000}; mem_aready = 1'b1;
        tick();
        req = 2'b00;
        tick();
        mem_rvalid = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (rvalid !== 2'b01) begin
            n_err++; $display("FAIL rst_beat2: got rvalid=%b expected 01", rvalid);
        end
        tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (any_out !== 1'b0) begin
            n_err++; $display("FAIL rst_abort: got nonzero outputs, expected all 0");
        end
`ifdef ARB_PERF_CNT_EN
        n_cmp++;
        if ({ic_wait_cnt, dc_wait_cnt} !== 128'd0) begin
            n_err++; $display("FAIL rst_perf: got %0d/%0d expected 0/0", ic_wait_cnt, dc_wait_cnt);
        end
`endif
        mem_rvalid = 1'b0;
        req = 2'b01; req_addr = {32'h0, 32'h8000_6000};
        tick();
        n_cmp++;
        if ({gnt, mem_addr} !== {2'b01, 32'h8000_6000}) begin
            n_err++; $display("FAIL rst_new_addr: got gnt=%b addr=%h expected 01 80006000", gnt, mem_addr);
        end
        req = 2'b00;
        tick();
        for (int b = 0; b < 4; b++) begin
            mem_rvalid = 1'b1;
            #1;
            n_cmp++;
            if ({rvalid, rlast} !== {2'b01, (b == 3)}) begin
                n_err++; $display("FAIL rst_new_beat%0d: got rvalid=%b rlast=%b expected 01 %b", b, rvalid, rlast, (b == 3));
            end
            tick();
        end
        mem_rvalid = 1'b0;
        #1;
        n_cmp++;
        if (any_out !== 1'b0) begin
            n_err++; $display("FAIL rst_new_idle: got nonzero outputs, expected idle");
        end
        $display("mid-transaction reset checked");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ic_read();
        test_dc_write();
        test_round_robin();
        test_aready_stall();
        test_rvalid_bubbles();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
